// File: rtl/coef_rom_arb_pkg.sv
// ============================================================================
// Module : coef_rom_arb_pkg
// Brief  : Shared types and default widths for the coefficient ROM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package coef_rom_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    typedef logic id_t;

endpackage

`default_nettype wire

// File: rtl/coef_out_slice.sv
// ============================================================================
// Module : coef_out_slice
// Brief  : Registered valid/ready output stage carrying data, last flag and id.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coef_out_slice #(
    parameter int DATA_W = coef_rom_arb_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_clear,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_last,
    input  coef_rom_arb_pkg::id_t   i_id,
    input  logic                    i_ready,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_valid,
    output logic                    o_last,
    output coef_rom_arb_pkg::id_t   o_id,
    output logic                    o_can_load
);
    import coef_rom_arb_pkg::*;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    id_t               r_id;

    // The register may take a new word when empty or when its word leaves this cycle.
    assign o_can_load = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_id    <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
            r_id    <= i_id;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_id    = r_id;

endmodule

`default_nettype wire

// File: rtl/coef_rom_arbiter.sv
// ============================================================================
// Module : coef_rom_arbiter
// Brief  : Round-robin burst arbiter sharing one coefficient ROM between two
//          requesters. Optional abort input enabled by COEF_ROM_ARB_ABORT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coef_rom_arbiter #(
    parameter int ADDR_W = coef_rom_arb_pkg::ADDR_W,
    parameter int DATA_W = coef_rom_arb_pkg::DATA_W,
    parameter int LEN_W  = coef_rom_arb_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] start0,
    input  logic [ADDR_W-1:0] start1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_id,
`ifdef COEF_ROM_ARB_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy
);
    import coef_rom_arb_pkg::*;

    localparam int CNT_W = LEN_W + 1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [CNT_W-1:0]  r_rem_q;
    id_t               r_id_q;
    id_t               r_rr;
    logic              r_gnt0;
    logic              r_gnt1;

    logic              w_sel;
    logic [LEN_W-1:0]  w_len_sel;
    logic [CNT_W-1:0]  w_len_ext;
    logic              w_rem_one;
    logic              w_abort;
    logic              w_grant;
    logic              w_load;
    logic              w_clear;
    logic              w_can_load;

`ifdef COEF_ROM_ARB_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Sole request wins; on a tie the round-robin pointer decides.
    assign w_sel     = (req0 && req1) ? r_rr : req1;
    assign w_len_sel = w_sel ? len1 : len0;
    assign w_len_ext = {(w_len_sel == '0), w_len_sel};
    assign w_rem_one = (r_rem_q == CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_can_load) begin
                    w_load = 1'b1;
                    if (w_rem_one) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr_q    <= '0;
            r_addr_hold <= '0;
            r_rem_q     <= '0;
            r_id_q      <= 1'b0;
            r_rr        <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt0  <= w_grant && !w_sel;
            r_gnt1  <= w_grant && w_sel;
            if (w_grant) begin
                r_addr_q <= w_sel ? start1 : start0;
                r_rem_q  <= w_len_ext;
                r_id_q   <= w_sel;
                r_rr     <= !w_sel;
            end else if (w_load) begin
                r_addr_q <= r_addr_q + ADDR_W'(1);
                r_rem_q  <= r_rem_q - CNT_W'(1);
            end
            // Remember the last streamed address so IDLE keeps it on the ROM pins.
            if (r_state == ST_STREAM) begin
                r_addr_hold <= r_addr_q;
            end
        end
    end

    coef_out_slice #(
        .DATA_W (DATA_W)
    ) u_out_slice (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_data     (rom_data),
        .i_last     (w_rem_one),
        .i_id       (r_id_q),
        .i_ready    (out_ready),
        .o_data     (out_data),
        .o_valid    (out_valid),
        .o_last     (out_last),
        .o_id       (out_id),
        .o_can_load (w_can_load)
    );

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign busy        = (r_state == ST_STREAM);
    assign rom_address = (r_state == ST_STREAM) ? r_addr_q : r_addr_hold;

endmodule

`default_nettype wire

// File: tb/tb_coef_rom_arbiter.sv
// ============================================================================
// Module : tb_coef_rom_arbiter
// Brief  : Self-checking bench for coef_rom_arbiter with a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coef_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  start0, start1;
    logic [7:0]  len0, len1;
    logic        gnt0, gnt1;
    logic [7:0]  rom_address;
    logic [15:0] rom_data;
    logic [15:0] out_data;
    logic        out_valid, out_ready, out_last, out_id, busy;
`ifdef COEF_ROM_ARB_ABORT_EN
    logic        abort;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        return 16'hA5C3 ^ {a, ~a};
    endfunction

    assign rom_data = rom_word(rom_address);

    coef_rom_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .start0      (start0),
        .start1      (start1),
        .len0        (len0),
        .len1        (len1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_id      (out_id),
`ifdef COEF_ROM_ARB_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        id;
    } word_t;

    word_t       exp_q[$];
    word_t       m_e;
    logic        m_rr;
    logic        p_req0, p_req1;
    logic [7:0]  p_s0, p_s1, p_l0, p_l1, m_s, m_l;
    int          m_w, m_n;
    logic        stall, stall_busy, s_last, s_id;
    logic [15:0] s_data;
    logic [7:0]  s_addr;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_rr   = 1'b0;
            stall  = 1'b0;
            p_req0 = 1'b0;
            p_req1 = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(s_data));
                check("hold_last_id", {30'd0, out_last, out_id}, {30'd0, s_last, s_id});
                if (stall_busy && busy && !(gnt0 || gnt1))
                    check("hold_addr", 32'(rom_address), 32'(s_addr));
            end
            if (gnt0 || gnt1) begin
                check("gnt_without_req", 32'(p_req0 || p_req1), 32'd1);
                m_w = (p_req0 && p_req1) ? int'(m_rr) : (p_req1 ? 1 : 0);
                check("gnt_winner", {30'd0, gnt1, gnt0}, (m_w == 1) ? 32'd2 : 32'd1);
                m_rr = (m_w == 0);
                m_s  = (m_w == 1) ? p_s1 : p_s0;
                m_l  = (m_w == 1) ? p_l1 : p_l0;
                m_n  = (m_l == 8'd0) ? 256 : int'(m_l);
                for (int i = 0; i < m_n; i++)
                    exp_q.push_back('{data: rom_word(m_s + 8'(i)), last: (i == m_n - 1), id: (m_w == 1)});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    m_e = exp_q.pop_front();
                    check("word", {14'd0, out_data, out_last, out_id}, {14'd0, m_e.data, m_e.last, m_e.id});
                end
            end
`ifdef COEF_ROM_ARB_ABORT_EN
            if (abort && busy) exp_q.delete();
`endif
            stall      = out_valid && !out_ready;
            stall_busy = busy;
            s_data     = out_data;
            s_last     = out_last;
            s_id       = out_id;
            s_addr     = rom_address;
            p_req0 = req0;  p_req1 = req1;
            p_s0   = start0; p_s1  = start1;
            p_l0   = len0;   p_l1  = len1;
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        logic [7:0] start;
        logic [7:0] len;
        logic       id;
        int         exp_n;
        logic [7:0] exp_last_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic run_burst(input vec_t v);
        if (v.id) begin req1 = 1'b1; start1 = v.start; len1 = v.len; end
        else      begin req0 = 1'b1; start0 = v.start; len0 = v.len; end
        tick();
        check("burst_gnt", {30'd0, gnt1, gnt0}, v.id ? 32'd2 : 32'd1);
        check("burst_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("burst_first_valid", 32'(out_valid), 32'd1);
        for (int k = 1; k < v.exp_n; k++) tick();
        check("burst_last_flags", {29'd0, out_valid, out_last, out_id}, {29'd0, 2'b11, v.id});
        check("burst_last_addr", 32'(rom_address), 32'(v.exp_last_addr));
        check("burst_last_data", 32'(out_data), 32'(rom_word(v.exp_last_addr)));
        tick();
        check("burst_drained", {30'd0, out_valid, busy}, 32'd0);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        out_ready = 1'b1;
        while ((busy || out_valid || req0 || req1) && k < limit) begin
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            tick();
            k++;
        end
        check("idle_timeout", {29'd0, busy, out_valid, (req0 || req1)}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
        check({tag, "_flags"}, {28'd0, out_valid, out_last, out_id, busy}, 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_addr"}, 32'(rom_address), 32'd0);
    endtask

    logic [15:0] bp_d;
    logic [7:0]  bp_a;
    logic        seen;

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        start0 = '0; start1 = '0; len0 = '0; len1 = '0;
        out_ready = 1'b1;
`ifdef COEF_ROM_ARB_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0] = '{8'd8,   8'd3, 1'b0, 3,   8'd10};
        vecs[1] = '{8'd254, 8'd4, 1'b1, 4,   8'd1};
        vecs[2] = '{8'd255, 8'd1, 1'b0, 1,   8'd255};
        vecs[3] = '{8'd100, 8'd0, 1'b1, 256, 8'd99};
        vecs[4] = '{8'd0,   8'd2, 1'b0, 2,   8'd1};

        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_burst(vecs[i]);

        // tie after reset: 0 first, 1 after burst 0, then 0 again
        reset = 1'b1; tick(); reset = 1'b0;
        req0 = 1'b1; start0 = 8'd16; len0 = 8'd2;
        req1 = 1'b1; start1 = 8'd32; len1 = 8'd2;
        tick();
        check("tie_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        repeat (3) tick();
        check("tie_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 1'b0;
        wait_idle(20);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie_again_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        wait_idle(30);

        // back-pressure for three cycles mid-burst
        req0 = 1'b1; start0 = 8'd40; len0 = 8'd6;
        tick(); req0 = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        bp_d = out_data;
        bp_a = rom_address;
        repeat (3) begin
            tick();
            check("bp_data", 32'(out_data), 32'(bp_d));
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_addr", 32'(rom_address), 32'(bp_a));
        end
        wait_idle(30);
        check("bp_all_words", 32'(exp_q.size()), 32'd0);

        // reset on the second word of an 8-word burst
        req0 = 1'b1; start0 = 8'd60; len0 = 8'd8;
        tick(); req0 = 1'b0;
        tick(); tick();
        check("rst_2nd_word", 32'(out_data), 32'(rom_word(8'd61)));
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin tick(); seen = seen | out_valid | busy; end
        check("rst_no_more_words", 32'(seen), 32'd0);

`ifdef COEF_ROM_ARB_ABORT_EN
        req0 = 1'b1; start0 = 8'd70; len0 = 8'd6;
        tick(); req0 = 1'b0;
        req1 = 1'b1; start1 = 8'd90; len1 = 8'd2;
        repeat (3) tick();
        check("ab_3rd_word", 32'(out_data), 32'(rom_word(8'd72)));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_cleared", {29'd0, out_valid, out_last, busy}, 32'd0);
        tick();
        check("ab_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 1'b0;
        wait_idle(20);
`endif

        // randomized traffic against the scoreboard
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (req0) begin
                if (gnt0) req0 = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                req0 = 1'b1;
                start0 = 8'($urandom);
                len0 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            end
            if (req1) begin
                if (gnt1) req1 = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                req1 = 1'b1;
                start1 = 8'($urandom);
                len1 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            end
            tick();
        end
        wait_idle(2000);
        check("rand_all_words", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
